// File: rtl/pio_out_pulse_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pio_out_pulse_pkg
// Description : Shared register map, STATUS bit positions and pulse FSM
//               state encoding for the pio_out_pulse output port.
// Revision    : 1.0 - initial release
// ============================================================================
package pio_out_pulse_pkg;

    // Register map (3-bit word address)
    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_SET    = 3'd1;
    localparam logic [2:0] ADDR_CLR    = 3'd2;
    localparam logic [2:0] ADDR_TGL    = 3'd3;
    localparam logic [2:0] ADDR_PULSE  = 3'd4;
    localparam logic [2:0] ADDR_LEN    = 3'd5;
    localparam logic [2:0] ADDR_STATUS = 3'd6;

    // STATUS register bit positions
    localparam int ST_BUSY = 0;
    localparam int ST_OVR  = 1;

    // One-shot pulse engine states
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        PULSE = 1'b1
    } pulse_state_t;

endpackage : pio_out_pulse_pkg
`default_nettype wire

// File: rtl/pio_out_pulse_timer.sv
`default_nettype none
// ============================================================================
// Module      : pio_out_pulse_timer
// Description : One-shot pulse engine. Captures the inversion mask, counts
//               the pulse length, raises a one-cycle done strobe and keeps
//               the sticky overrun flag for starts issued while busy.
// Revision    : 1.0 - initial release
// ============================================================================
module pio_out_pulse_timer
    import pio_out_pulse_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [WIDTH-1:0] start_mask_i,
    input  logic [CNT_W-1:0] len_i,
    input  logic             ovr_clr_i,
    output logic [WIDTH-1:0] mask_o,
    output logic             busy_o,
    output logic             pulse_done_o,
    output logic             ovr_o
);

    pulse_state_t     state_q;
    logic [WIDTH-1:0] mask_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             ovr_q;

    // Pulse FSM: counter loaded with max(LEN,1)-1 so the mask is applied for
    // exactly max(LEN,1) cycles; overrun set is ordered after clear so it wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            mask_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (ovr_clr_i) begin
                ovr_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (start_i && (start_mask_i != '0)) begin
                        mask_q  <= start_mask_i;
                        cnt_q   <= (len_i == '0) ? '0 : (len_i - CNT_W'(1));
                        busy_q  <= 1'b1;
                        state_q <= PULSE;
                    end
                end
                PULSE: begin
                    if (start_i) begin
                        ovr_q <= 1'b1;
                    end
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        busy_q  <= 1'b0;
                        mask_q  <= '0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mask_o       = mask_q;
    assign busy_o       = busy_q;
    assign pulse_done_o = done_q;
    assign ovr_o        = ovr_q;

endmodule : pio_out_pulse_timer
`default_nettype wire

// File: rtl/pio_out_pulse.sv
`default_nettype none
// ============================================================================
// Module      : pio_out_pulse
// Description : Avalon-MM output port with set/clear/toggle aliases and a
//               hardware one-shot pulse engine that inverts selected bits
//               for a programmable number of cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module pio_out_pulse
    import pio_out_pulse_pkg::*;
#(
    parameter int               WIDTH             = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE       = {WIDTH{1'b1}},
    parameter int               CNT_W             = 16,
    parameter int               DEFAULT_PULSE_LEN = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             busy,
    output logic             pulse_done
);

    localparam logic [CNT_W-1:0] C_LEN_RST = CNT_W'(DEFAULT_PULSE_LEN);

    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             w_wr;
    logic             w_pulse_start;
    logic             w_ovr_clr;
    logic [WIDTH-1:0] w_mask;
    logic             w_busy;
    logic             w_ovr;
    logic             w_unused_wd;

    assign w_wr          = chipselect & ~write_n;
    assign w_pulse_start = w_wr && (address == ADDR_PULSE);
    assign w_ovr_clr     = w_wr && (address == ADDR_STATUS) && writedata[ST_OVR];
    assign w_unused_wd   = ^writedata;

    // Next-state for DATA (direct write and atomic aliases) and LEN
    always_comb begin
        data_d = data_q;
        len_d  = len_q;
        if (w_wr) begin
            case (address)
                ADDR_DATA: data_d = writedata[WIDTH-1:0];
                ADDR_SET:  data_d = data_q | writedata[WIDTH-1:0];
                ADDR_CLR:  data_d = data_q & ~writedata[WIDTH-1:0];
                ADDR_TGL:  data_d = data_q ^ writedata[WIDTH-1:0];
                ADDR_LEN:  len_d  = writedata[CNT_W-1:0];
                default:   ;
            endcase
        end
    end

    // DATA and LEN registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= RESET_VALUE;
            len_q  <= C_LEN_RST;
        end else begin
            data_q <= data_d;
            len_q  <= len_d;
        end
    end

    pio_out_pulse_timer #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_timer (
        .clk          (clk),
        .reset        (reset),
        .start_i      (w_pulse_start),
        .start_mask_i (writedata[WIDTH-1:0]),
        .len_i        (len_q),
        .ovr_clr_i    (w_ovr_clr),
        .mask_o       (w_mask),
        .busy_o       (w_busy),
        .pulse_done_o (pulse_done),
        .ovr_o        (w_ovr)
    );

    // Read mux, zero-extended; reads have no side effects
    always_comb begin
        readdata = 32'd0;
        case (address)
            ADDR_DATA:   readdata = 32'(data_q);
            ADDR_PULSE:  readdata = 32'(w_mask);
            ADDR_LEN:    readdata = 32'(len_q);
            ADDR_STATUS: begin
                readdata[ST_BUSY] = w_busy;
                readdata[ST_OVR]  = w_ovr;
            end
            default:     readdata = 32'd0;
        endcase
    end

    // Pins are an XOR of registered sources only, so each bit is glitch-free
    assign out_port = data_q ^ (w_busy ? w_mask : '0);
    assign busy     = w_busy;

endmodule : pio_out_pulse
`default_nettype wire

// File: tb/tb_pio_out_pulse.sv
`default_nettype none
// ============================================================================
// Module      : tb_pio_out_pulse
// Description : Directed self-checking bench for pio_out_pulse (WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pio_out_pulse;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic        busy;
    logic        pulse_done;

    int n_checks = 0;
    int n_pass   = 0;

    pio_out_pulse dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .busy       (busy),
        .pulse_done (pulse_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
        address = a;
        #1;
        chk(tag, readdata, exp);
    endtask

    initial begin
        // 1. Reset defaults
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_out", 32'(out_port), 32'hFF);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(pulse_done), 32'd0);
        rd("rst_data", 3'd0, 32'h000000FF);
        rd("rst_len", 3'd5, 32'd1000);
        rd("rst_status", 3'd6, 32'd0);
        rd("rst_mask", 3'd4, 32'd0);

        // 2. Data write and aliases
        wr(3'd0, 32'hA5); chk("wr_data", 32'(out_port), 32'hA5);
        wr(3'd1, 32'h0F); chk("wr_set", 32'(out_port), 32'hAF);
        wr(3'd2, 32'h03); chk("wr_clr", 32'(out_port), 32'hAC);
        wr(3'd3, 32'hFF); chk("wr_tgl", 32'(out_port), 32'h53);
        rd("rd_set_alias", 3'd1, 32'd0);

        // 3a. 4-cycle pulse on bit0
        wr(3'd5, 32'd4);
        wr(3'd0, 32'hFF);
        wr(3'd4, 32'h01);
        chk("p_out_0", 32'(out_port), 32'hFE);
        chk("p_busy_0", 32'(busy), 32'd1);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("p_out_n", 32'(out_port), 32'hFE);
            chk("p_busy_n", 32'(busy), 32'd1);
            chk("p_done_n", 32'(pulse_done), 32'd0);
        end
        tick();
        chk("p_end_busy", 32'(busy), 32'd0);
        chk("p_end_done", 32'(pulse_done), 32'd1);
        chk("p_end_out", 32'(out_port), 32'hFF);
        tick();
        chk("p_done_clr", 32'(pulse_done), 32'd0);

        // 3b. DATA write mid-pulse
        wr(3'd4, 32'h01);
        wr(3'd0, 32'h7F);
        chk("mid_out", 32'(out_port), 32'h7E);
        tick();
        tick();
        chk("mid_busy", 32'(busy), 32'd1);
        tick();
        chk("mid_end_busy", 32'(busy), 32'd0);
        chk("mid_end_out", 32'(out_port), 32'h7F);
        wr(3'd0, 32'hFF);

        // 4. Overrun
        wr(3'd4, 32'h01);
        wr(3'd4, 32'h02);
        chk("ovr_out", 32'(out_port), 32'hFE);
        rd("ovr_mask", 3'd4, 32'h01);
        rd("ovr_status", 3'd6, 32'h3);
        tick();
        tick();
        chk("ovr_len_busy", 32'(busy), 32'd1);
        tick();
        chk("ovr_len_end", 32'(busy), 32'd0);
        chk("ovr_len_done", 32'(pulse_done), 32'd1);
        rd("ovr_sticky", 3'd6, 32'h2);
        wr(3'd6, 32'h2);
        rd("ovr_cleared", 3'd6, 32'h0);

        // 5. LEN=0 -> one cycle, and zero mask ignored
        wr(3'd5, 32'd0);
        wr(3'd4, 32'h80);
        chk("len0_out", 32'(out_port), 32'h7F);
        chk("len0_busy", 32'(busy), 32'd1);
        tick();
        chk("len0_end", 32'(out_port), 32'hFF);
        chk("len0_done", 32'(pulse_done), 32'd1);
        wr(3'd4, 32'h00);
        chk("zmask_busy", 32'(busy), 32'd0);
        chk("zmask_done", 32'(pulse_done), 32'd0);
        tick();
        chk("zmask_done2", 32'(pulse_done), 32'd0);
        rd("zmask_status", 3'd6, 32'd0);

        // 6. Asynchronous reset mid-pulse
        wr(3'd5, 32'd100);
        wr(3'd4, 32'h01);
        repeat (9) tick();
        chk("ar_busy_pre", 32'(busy), 32'd1);
        chk("ar_out_pre", 32'(out_port), 32'hFE);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_out", 32'(out_port), 32'hFF);
        chk("ar_busy", 32'(busy), 32'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ar_no_done", 32'(pulse_done), 32'd0);
            chk("ar_no_busy", 32'(busy), 32'd0);
        end
        rd("ar_len", 3'd5, 32'd1000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_pio_out_pulse
`default_nettype wire

// File: doc/pio_out_pulse.md
Name: pio_out_pulse

Overview:
Parametrised Avalon-MM slave output port, successor to the single-bit PIO used for panel reset and control lines.
Drives WIDTH output bits from a data register, with atomic set/clear/toggle write aliases.
Adds a hardware one-shot pulse engine: selected bits are inverted for a programmable number of clk cycles, then restored automatically. CPU software no longer has to time reset pulses.
Sits on the system interconnect beside the other PIOs; out_port goes straight to pins (LCD_RST, backlight enable, etc.).

Parameters:
WIDTH, 8, number of output bits (1..32)
RESET_VALUE, {WIDTH{1'b1}}, data register and out_port value at reset
CNT_W, 16, pulse length counter width (1..32)
DEFAULT_PULSE_LEN, 1000, pulse length register reset value (truncated to CNT_W)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
address  in  3  register select
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data; only low WIDTH (or CNT_W) bits used
readdata  out  32  combinational read mux, zero-extended
out_port  out  WIDTH  pin outputs
busy  out  1  pulse in progress
pulse_done  out  1  one-cycle strobe when pulse ends

Behaviour:
- Write = chipselect & ~write_n, sampled at posedge clk. No wait states. No read side effects.
- Register map (addr: write / read):
  - 0: DATA <= wd / DATA
  - 1: DATA <= DATA | wd / 0
  - 2: DATA <= DATA & ~wd / 0
  - 3: DATA <= DATA ^ wd / 0
  - 4: PULSE start with mask=wd / active MASK
  - 5: LEN <= wd[CNT_W-1:0] / LEN
  - 6: STATUS, write 1 to bit1 clears OVR / {30'b0, OVR, busy}
  - 7: none / 0
- out_port = DATA ^ (busy ? MASK : 0). Registered sources only, glitch-free per bit.
- DATA write latency: value written at edge N is visible on out_port after edge N.
- Reset (async, immediate) sets:
  - DATA=RESET_VALUE, LEN=DEFAULT_PULSE_LEN
  - MASK=0, cnt=0, busy=0, pulse_done=0, OVR=0
  - therefore out_port=RESET_VALUE.
- Pulse FSM, states IDLE / PULSE:
  - IDLE, write addr 4 with wd[WIDTH-1:0]!=0 at edge N:
    - MASK<=wd, cnt<=max(LEN,1)-1, busy<=1, go to PULSE.
  - IDLE, mask==0: ignored, stay IDLE, OVR unchanged.
  - PULSE, cnt!=0: cnt decrements each edge.
  - PULSE, cnt==0 at an edge: busy<=0, MASK<=0, pulse_done<=1 for one cycle, go to IDLE.
  - Net timing: mask bits inverted for exactly max(LEN,1) cycles (edge N to edge N+max(LEN,1)). pulse_done is high in the cycle after the final edge.
- LEN=0 is treated as 1.
- LEN written during PULSE affects the next pulse only.
- Write addr 4 while busy (including the terminating cycle): ignored, OVR<=1 (sticky).
- DATA writes during PULSE take effect immediately; out_port = new DATA ^ MASK.
- Write to STATUS with bit1=1 in the same cycle as an overrun event: the set wins, OVR=1.
- Reset asserted mid-pulse: busy, MASK and cnt clear immediately. No pulse_done.

Decomposition:
- Shared package holds:
  - register address constants (ADDR_DATA=0, ADDR_SET=1, ADDR_CLR=2, ADDR_TGL=3, ADDR_PULSE=4, ADDR_LEN=5, ADDR_STATUS=6)
  - STATUS bit indices (ST_BUSY=0, ST_OVR=1)
  - FSM state enum {IDLE, PULSE}
- One natural sub-module: pio_pulse_timer (cnt, busy, pulse_done, MASK capture, OVR). The top keeps DATA/LEN registers, the read mux and the output XOR.

Test Plan:
1. Defaults (WIDTH=8). Reset pulse, release -> out_port=8'hFF; read addr0=32'h000000FF; addr5=32'd1000; addr6=0; busy=0.
2. Write addr0=8'hA5, then addr1=8'h0F, then addr2=8'h03, then addr3=8'hFF -> out_port 8'hA5, 8'hAF, 8'hAC, 8'h53, each visible the cycle after its write.
3. Set LEN=4, DATA=8'hFF, write addr4=8'h01 at edge N:
   - out_port=8'hFE and busy=1 for exactly 4 cycles;
   - pulse_done=1 for one cycle after edge N+4, then out_port=8'hFF.
   - A write of DATA=8'h7F mid-pulse gives out_port=8'h7E.
4. During a pulse, write addr4=8'h02 -> no MASK change, pulse length unchanged, addr6 reads 2'b11. After completion, write addr6=32'h2 -> addr6 reads 0.
5. LEN=0, write addr4=8'h80 -> 1-cycle pulse (out_port bit7 low one cycle). Write addr4=8'h00 -> busy stays 0, no pulse_done.
6. LEN=100, start pulse, assert reset asynchronously 10 cycles in -> out_port=8'hFF and busy=0 without waiting for clk. No pulse_done after release.
